// File: rtl/data_mem_subsystem.sv
// data_mem_subsystem
//   Data-side memory path for the cpu's byte loads and stores. It has two parts:
//   - A direct-mapped, write-back, write-allocate cache of 8 blocks x 4 bytes.
//   - A 64 x 32-bit word memory behind the cache, with a fixed latency.
//   The cpu holds read/write, address and writedata until busywait drops.
//
// Ports
//   clock      system clock; all state changes on posedge
//   reset      asynchronous, active-high; clears FSM, valid/dirty and memory
//   read       load request
//   write      store request (never together with read)
//   address    byte address: tag[7:5] index[4:2] offset[1:0]
//   writedata  store byte
//   readdata   load byte; 8'h00 whenever read=0
//   busywait   stall request to the cpu
module data_mem_subsystem #(
    parameter int MEM_LATENCY = 5   // cycles per block read / block write (>= 2)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [2:0]  tag;
        logic [31:0] data;
    } blk_t;

    typedef enum logic [1:0] {IDLE, WB, FETCH, UPDATE} state_t;

    blk_t        blk_q [8];
    logic [31:0] mem_q [64];
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [5:0]  mem_addr_q;     // word address of the transfer in flight

    logic [2:0]  tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    blk_t        cur;
    logic        req;
    logic        hit;

    assign tag = address[7:5];
    assign idx = address[4:2];
    assign off = address[1:0];
    assign cur = blk_q[idx];
    assign req = read | write;
    assign hit = cur.valid && (cur.tag == tag);

    assign busywait = req & ~((state_q == IDLE) & hit);
    assign readdata = read ? cur.data[{off, 3'b000} +: 8] : 8'h00;

    // The block read spans MEM_LATENCY cycles. Its last cycle is UPDATE, where
    // the word is taken straight from the array into the block. FETCH therefore
    // only waits MEM_LATENCY-1 cycles. The write-back holds WB for the full
    // MEM_LATENCY cycles and commits on the way out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (req && !hit) state_d = cur.dirty ? WB : FETCH;
            WB:     if (cnt_q == CW'(MEM_LATENCY - 1)) state_d = FETCH;
            FETCH:  if (cnt_q == CW'(MEM_LATENCY - 2)) state_d = UPDATE;
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            for (int i = 0; i < 8; i++)  blk_q[i] <= '0;
            for (int i = 0; i < 64; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;

            // Latch the transfer address on entry to WB (victim) or FETCH (request).
            if (state_q == IDLE && state_d == WB)
                mem_addr_q <= {cur.tag, idx};
            if (state_d == FETCH && state_q != FETCH)
                mem_addr_q <= address[7:2];

            // The write-back uses the victim address latched earlier. The
            // nonblocking update above switches the address to the fetch word
            // only after this commit.
            if (state_q == WB && state_d == FETCH)
                mem_q[mem_addr_q] <= cur.data;

            if (state_q == UPDATE)
                blk_q[idx] <= {1'b1, 1'b0, tag, mem_q[mem_addr_q]};

            // Store hit merges one byte. After a miss, the store retires here on
            // its first IDLE cycle, once the block has been allocated.
            if (state_q == IDLE && write && hit) begin
                blk_q[idx].data[{off, 3'b000} +: 8] <= writedata;
                blk_q[idx].dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_subsystem.sv
// Directed bench for data_mem_subsystem. Each access is driven on a negedge and
// held until busywait drops. The bench counts stall cycles and compares them,
// along with readdata and selected internal state, against hand-derived values.
module tb_data_mem_subsystem;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       busywait;

    int nchk = 0;
    int nerr = 0;

    data_mem_subsystem #(.MEM_LATENCY(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        read = 1'b0; write = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One cpu access, held until busywait drops. The loop is bounded at 100
    // cycles, so a hang shows up as a stall mismatch.
    task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output int stall, output logic [7:0] rd);
        @(negedge clock);
        read = ~wr; write = wr; address = a; writedata = d;
        stall = 0;
        #1;
        while (busywait && stall < 100) begin
            stall++;
            @(negedge clock);
            #1;
        end
        rd = readdata;
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        int stall;
        logic [7:0] rd;

        #12 reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busywait}, 32'd0);
        chk("rst_rdata", {24'd0, readdata}, 32'd0);

        // 1: clean read miss
        access(1'b0, 8'h05, 8'h00, stall, rd);
        chk("t1_stall", stall, 6);
        chk("t1_rdata", {24'd0, rd}, 32'h00);
        chk("t1_valid", {31'd0, dut.blk_q[1].valid}, 32'd1);
        chk("t1_dirty", {31'd0, dut.blk_q[1].dirty}, 32'd0);
        access(1'b0, 8'h05, 8'h00, stall, rd);
        chk("t1_rehit_stall", stall, 0);

        // 2: store miss allocates, then a load hit
        do_reset();
        access(1'b1, 8'h02, 8'h02, stall, rd);
        chk("t2_wstall", stall, 6);
        chk("t2_dirty", {31'd0, dut.blk_q[0].dirty}, 32'd1);
        chk("t2_tag", {29'd0, dut.blk_q[0].tag}, 32'd0);
        chk("t2_data", dut.blk_q[0].data, 32'h0002_0000);
        access(1'b0, 8'h02, 8'h00, stall, rd);
        chk("t2_rstall", stall, 0);
        chk("t2_rdata", {24'd0, rd}, 32'h02);

        // 3: conflicting store evicts the dirty block
        access(1'b1, 8'h22, 8'h02, stall, rd);
        chk("t3_stall", stall, 11);
        chk("t3_mem0", dut.mem_q[0], 32'h0002_0000);
        chk("t3_tag", {29'd0, dut.blk_q[0].tag}, 32'd1);
        chk("t3_dirty", {31'd0, dut.blk_q[0].dirty}, 32'd1);

        // 4: dirty read miss, then the reloaded block is clean, so a clean miss
        access(1'b0, 8'h42, 8'h00, stall, rd);
        chk("t4a_stall", stall, 11);
        chk("t4a_mem8", dut.mem_q[8], 32'h0002_0000);
        chk("t4a_rdata", {24'd0, rd}, 32'h00);
        access(1'b0, 8'h22, 8'h00, stall, rd);
        chk("t4b_stall", stall, 6);
        chk("t4b_rdata", {24'd0, rd}, 32'h02);

        // 5: allocate via store, then a store hit in the same block
        do_reset();
        access(1'b1, 8'h07, 8'hAB, stall, rd);
        chk("t5a_stall", stall, 6);
        access(1'b1, 8'h04, 8'hCD, stall, rd);
        chk("t5b_stall", stall, 0);
        chk("t5_word", dut.blk_q[1].data, 32'hAB00_00CD);
        access(1'b0, 8'h04, 8'h00, stall, rd);
        chk("t5_b0", {24'd0, rd}, 32'hCD);
        access(1'b0, 8'h07, 8'h00, stall, rd);
        chk("t5_b3", {24'd0, rd}, 32'hAB);
        access(1'b0, 8'h06, 8'h00, stall, rd);
        chk("t5_b2", {24'd0, rd}, 32'h00);

        // push the dirty block out so memory holds non-zero data
        access(1'b0, 8'h25, 8'h00, stall, rd);
        chk("t6_wb_stall", stall, 11);
        chk("t6_mem1", dut.mem_q[1], 32'hAB00_00CD);

        // 6: reset in the middle of a FETCH
        @(negedge clock);
        read = 1'b1; address = 8'h09;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("t6_busy_fetch", {31'd0, busywait}, 32'd1);
        reset = 1'b1; read = 1'b0;
        #1;
        chk("t6_busy_rst", {31'd0, busywait}, 32'd0);
        chk("t6_valid1", {31'd0, dut.blk_q[1].valid}, 32'd0);
        chk("t6_mem1_clr", dut.mem_q[1], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        access(1'b0, 8'h05, 8'h00, stall, rd);
        chk("t6_post_stall", stall, 6);
        chk("t6_post_rdata", {24'd0, rd}, 32'h00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
